// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants, opcode encoding and Barrett constant helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ntt_pkg;

    localparam int unsigned Q_DILITHIUM = 8380417;
    localparam int unsigned Q_KYBER     = 3329;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    // floor(2^(2w) / q); fits in w+1 bits because 2^(w-1) < q < 2^w
    function automatic longint unsigned mu_of(input longint unsigned q, input int unsigned w);
        return (64'd1 << (2 * w)) / q;
    endfunction

endpackage

// File: rtl/barrett_reduce.sv
// Barrett reduction of a 2W-bit product into [0, Q): quotient estimate, subtract, final correction.
// Latency: 3 enabled cycles (quotient, remainder, correction); result register resets to 0.
// Backpressure: all stages hold together while en is low.
module barrett_reduce #(
    parameter int unsigned      Q  = 8380417,
    parameter int unsigned      W  = $clog2(Q),
    parameter longint unsigned  MU = ntt_pkg::mu_of(Q, W)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [2*W-1:0] i_p,
    input  logic           i_mul,
    output logic [W-1:0]   o_z
);

    localparam logic [W:0]   MU_W = (W + 1)'(MU);
    localparam logic [W+1:0] Q_R  = (W + 2)'(Q);
    localparam logic [W+1:0] Q2_R = (W + 2)'(2 * Q);

    logic [W:0]   w_hi;
    logic [W:0]   w_t;
    logic [W+1:0] w_tq;
    logic [W-1:0] w_red;

    logic [W:0]   r_t;
    logic [W+1:0] r_pl;
    logic [W+1:0] r_r;
    logic [W-1:0] r_z;

    assign w_hi = i_p[2*W-1:W-1];
    assign w_t  = (W + 1)'(({{(W + 1){1'b0}}, w_hi} * {{(W + 1){1'b0}}, MU_W}) >> (W + 1));

    // Only the low W+2 bits of p are needed: the true remainder is below 3Q < 2^(W+2)
    always_ff @(posedge clk) begin
        if (en) begin
            r_t  <= i_mul ? w_t : '0;
            r_pl <= i_p[W+1:0];
        end
    end

    assign w_tq = {1'b0, r_t} * Q_R;

    always_ff @(posedge clk) begin
        if (en) begin
            r_r <= r_pl - w_tq;
        end
    end

    always_comb begin
        w_red = W'(r_r);
        if (r_r >= Q2_R) begin
            w_red = W'(r_r - Q2_R);
        end else if (r_r >= Q_R) begin
            w_red = W'(r_r - Q_R);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z <= '0;
        end else if (en) begin
            r_z <= w_red;
        end
    end

    assign o_z = r_z;

endmodule

// File: rtl/mod_arith_pipe.sv
// Pipelined z = a*b / a+b / a-b / a mod Q with a sideband tag, results in acceptance order.
// Latency: 4 advancing cycles from accept to out_valid; one op per clock at full rate.
// Backpressure: whole pipe stalls while out_valid & !out_ready; in_ready mirrors that.
module mod_arith_pipe
    import ntt_pkg::*;
#(
    parameter int unsigned       Q     = Q_DILITHIUM,
    parameter int unsigned       TAG_W = 8,
    localparam int unsigned      W     = $clog2(Q),
    localparam longint unsigned  MU    = mu_of(Q, W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_z,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam logic [2*W-1:0] Q_P = (2 * W)'(Q);

    logic             w_adv;
    logic [2*W-1:0]   w_a;
    logic [2*W-1:0]   w_b;
    logic [2*W-1:0]   w_p;

    logic [3:0]       r_vld;
    logic [2*W-1:0]   r_p1;
    logic             r_mul1;
    logic [TAG_W-1:0] r_tag [3];
    logic [TAG_W-1:0] r_out_tag;

    assign w_adv     = !r_vld[3] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_vld[3];
    assign out_tag   = r_out_tag;
    assign busy      = |r_vld;

    assign w_a = {{W{1'b0}}, in_a};
    assign w_b = {{W{1'b0}}, in_b};

    // SUB adds Q so the value stays non-negative ahead of the shared reduction
    always_comb begin
        w_p = w_a;
        case (op_e'(in_op))
            OP_MUL:  w_p = w_a * w_b;
            OP_ADD:  w_p = w_a + w_b;
            OP_SUB:  w_p = w_a - w_b + Q_P;
            default: w_p = w_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld     <= '0;
            r_out_tag <= '0;
        end else if (w_adv) begin
            r_vld     <= {r_vld[2:0], in_valid};
            r_out_tag <= r_tag[2];
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_p1     <= w_p;
            r_mul1   <= (op_e'(in_op) == OP_MUL);
            r_tag[0] <= in_tag;
            r_tag[1] <= r_tag[0];
            r_tag[2] <= r_tag[1];
        end
    end

    barrett_reduce #(
        .Q  (Q),
        .W  (W),
        .MU (MU)
    ) u_reduce (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_adv),
        .i_p   (r_p1),
        .i_mul (r_mul1),
        .o_z   (out_z)
    );

endmodule
